mac_result_requant: RTL

MAC_RESULT_REQUANT -- requirements
Module: mac_result_requant

---
 rtl/mac_result_requant.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mac_result_requant.sv
// Requantizes 32-bit signed MAC results to 16-bit samples: it rounds half toward +inf, shifts by SHIFT, saturates, and buffers the samples in a DEPTH-entry FIFO.
// Optional saturation counter is enabled by defining REQUANT_SAT_COUNT_EN.
module mac_result_requant #(
  parameter int unsigned SHIFT = 15,
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  input  logic        clear_count,
  output logic [15:0] sat_count
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = PTR_W + 1;

  logic signed [32:0] ext_c;
  logic signed [32:0] rnd_c;
  logic               sat_hi_c;
  logic               sat_lo_c;
  logic               sat_c;
  logic [DATA_W-1:0]  sample_c;

  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push_c;
  logic               pop_c;

  assign ext_c = {in_data[31], in_data};

  // Rounding constant only exists when there is something to shift out.
  generate
    if (SHIFT == 0) begin : g_no_round
      assign rnd_c = ext_c;
    end else begin : g_round
      localparam logic signed [32:0] HALF = 33'sd1 <<< (SHIFT - 1);
      assign rnd_c = (ext_c + HALF) >>> SHIFT;
    end
  endgenerate

  assign sat_hi_c = (rnd_c > 33'sd32767);
  assign sat_lo_c = (rnd_c < -33'sd32768);
  assign sat_c    = sat_hi_c | sat_lo_c;

  always_comb begin
    sample_c = rnd_c[DATA_W-1:0];
    if (sat_hi_c) begin
      sample_c = 16'h7FFF;
    end else if (sat_lo_c) begin
      sample_c = 16'h8000;
    end
  end

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push_c    = in_valid & in_ready;
  assign pop_c     = out_valid & out_ready;
  // An empty FIFO shows zero, so reset clears out_data without clearing the storage.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= sample_c;
    end
  end

`ifdef REQUANT_SAT_COUNT_EN
  logic [15:0] sat_q, sat_d;

  // Clear wins over a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    sat_d = sat_q;
    if (clear_count) begin
      sat_d = '0;
    end else if (push_c && sat_c && (sat_q != 16'hFFFF)) begin
      sat_d = sat_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sat_q <= '0;
    end else begin
      sat_q <= sat_d;
    end
  end

  assign sat_count = sat_q;
`else
  logic sat_unused;
  assign sat_unused = clear_count ^ sat_c;
  assign sat_count  = '0;
`endif

endmodule
